// File: rtl/c17_bist_ctrl_if.sv
// Handshake/bus bundle between the c17 BIST controller (slave side) and the
// harness holding the c17 instance (master side).
interface c17_bist_ctrl_if;
    // start is a level sampled on every rising edge. It has no ready
    // partner: a run is accepted only in IDLE/DONE and ignored otherwise.
    // busy, done, pass, signature and dbg_state are registered status.
    logic       start;
    logic [4:0] cut_in;
    logic [1:0] cut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
    logic [1:0] dbg_state;

    modport slave (
        input  start,
        input  cut_out,
        output cut_in,
        output busy,
        output done,
        output pass,
        output signature,
        output dbg_state
    );

    modport master (
        output start,
        output cut_out,
        input  cut_in,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  dbg_state
    );
endinterface

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 benchmark: 5-bit LFSR stimulus, 8-bit MISR
// compaction, golden compare. Optional macro BIST_ZERO_PATTERN_EN adds an all-zero pattern.
module c17_bist_ctrl #(
    parameter int         N_PAT  = 31,
    parameter logic [4:0] SEED   = 5'h01,
    parameter logic [7:0] GOLDEN = 8'h00
) (
    input logic            clock,
    input logic            reset,
    c17_bist_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef BIST_ZERO_PATTERN_EN
    // One extra counter value covers the trailing all-zero pattern.
    localparam int CW   = 6;
    localparam int LAST = N_PAT;
`else
    localparam int CW   = 5;
    localparam int LAST = N_PAT - 1;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
    localparam logic [4:0]    SEED_EFF = (SEED == 5'h00) ? 5'h01 : SEED;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_lfsr;
    logic [4:0]    w_lfsr_nxt;
    logic [7:0]    r_misr;
    logic [7:0]    w_misr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_pass;
    logic          w_pass_nxt;
    logic          w_misr_fb;
    logic          w_lfsr_fb;
    logic          w_zero_cycle;

    assign w_misr_fb = r_misr[7] ^ r_misr[3] ^ r_misr[2] ^ r_misr[1];
    assign w_lfsr_fb = r_lfsr[4] ^ r_lfsr[2];

`ifdef BIST_ZERO_PATTERN_EN
    assign w_zero_cycle = (r_state == S_RUN) && (r_cnt == CNT_LAST);
`else
    assign w_zero_cycle = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED_EFF;
            r_misr  <= 8'h00;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_misr  <= w_misr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_misr_nxt  = r_misr;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_lfsr_nxt  = SEED_EFF;
                    w_misr_nxt  = 8'h00;
                    w_cnt_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // cut_out is the same-cycle response to the current cut_in.
                w_misr_nxt = {r_misr[6:0], w_misr_fb} ^ {6'b0, bus.cut_out};
                if (!w_zero_cycle) begin
                    w_lfsr_nxt = {r_lfsr[3:0], w_lfsr_fb};
                end
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_pass_nxt  = (r_misr == GOLDEN);
                w_done_nxt  = 1'b1;
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cut_in    = w_zero_cycle ? 5'b00000 : r_lfsr;
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_CHECK);
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.signature = r_misr;
    assign bus.dbg_state = r_state;

endmodule
